gameover_overlay_ctrl: RTL and testbench

Sequences reads of the 211x25 "Game Over" sprite ROM (5-bit palette indices, 15-bit address, 1-cycle registered read) against the VGA raster. On game-over it animates the banner dropping from the top of the screen to a rest row. It then emits a pipelined, latency-aligned overlay pixel (valid + palette index) to the colour mapper, which gives the overlay priority over the playfield.

---
 rtl/gameover_overlay_ctrl_pkg.sv | 22 ++
 rtl/gameover_overlay_ctrl_sprite_addr_gen.sv | 59 +++++
 rtl/gameover_overlay_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gameover_overlay_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gameover_overlay_ctrl_pkg.sv
// boxhead_sprite_pkg: shared constants and types for the sprite overlay
// controllers. Holds the "Game Over" banner geometry, the ROM interface
// widths and the controller state type.
package boxhead_sprite_pkg;

    localparam int GO_SPRITE_W  = 211;
    localparam int GO_SPRITE_H  = 25;
    localparam int GO_ROM_AW    = 15;
    localparam int GO_IDX_W     = 5;
    localparam int GO_X0        = 214;
    localparam int GO_Y_TARGET  = 227;
    localparam int GO_DROP_STEP = 4;

    localparam logic [GO_IDX_W-1:0] TRANSPARENT_IDX = '0;

    typedef enum logic [1:0] {
        GO_IDLE = 2'd0,
        GO_DROP = 2'd1,
        GO_SHOW = 2'd2
    } go_state_t;

endpackage

// File: rtl/gameover_overlay_ctrl_sprite_addr_gen.sv
// sprite_addr_gen: hit test and ROM address generation for one rectangular
// sprite, with one register stage. Reusable for any sprite ROM.
//   clk, reset        : clock, synchronous active-high reset
//   en                : sprite enabled (no hit when low)
//   draw_x, draw_y    : raster position
//   x0, y0, w, h      : sprite box (top-left corner and size)
//   rom_addr          : registered ROM address (0 outside the box)
//   in_box            : registered hit flag, aligned with rom_addr
module sprite_addr_gen
    import boxhead_sprite_pkg::*;
#(
    parameter int AW = GO_ROM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic [9:0]    x0,
    input  logic [9:0]    y0,
    input  logic [9:0]    w,
    input  logic [9:0]    h,
    output logic [AW-1:0] rom_addr,
    output logic          in_box
);

    logic [10:0]   x_end, y_end;
    logic [9:0]    dx, dy;
    logic          in_box_d, in_box_q;
    logic [AW-1:0] rom_addr_d, rom_addr_q;

    always_comb begin
        // One extra bit so the box end cannot wrap.
        x_end    = {1'b0, x0} + {1'b0, w};
        y_end    = {1'b0, y0} + {1'b0, h};
        dx       = draw_x - x0;
        dy       = draw_y - y0;
        in_box_d = en
                 & (draw_x >= x0) & ({1'b0, draw_x} < x_end)
                 & (draw_y >= y0) & ({1'b0, draw_y} < y_end);
        rom_addr_d = '0;
        if (in_box_d)
            rom_addr_d = AW'(dy) * AW'(w) + AW'(dx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            in_box_q   <= in_box_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign in_box   = in_box_q;

endmodule

// File: rtl/gameover_overlay_ctrl.sv
// gameover_overlay_ctrl: drops the "Game Over" banner from the top of the
// screen to its rest row, then reads the sprite ROM against the raster and
// emits a 2-cycle latency overlay pixel for the colour mapper.
//   Clk, Reset     : clock, synchronous active-high reset
//   frame_tick     : one pulse per frame; advances the drop / blink
//   game_over      : level; rising edge starts the sequence
//   restart        : pulse; returns to idle (beats a same-cycle start)
//   DrawX, DrawY   : raster position
//   rom_addr       : sprite ROM address, rom_data returns one cycle later
//   overlay_valid  : opaque banner pixel, overlay_idx its palette index
//   active         : sequence running, settled : banner at rest row
// Optional: define GAMEOVER_BLINK_EN to blink the settled banner
// (30 frames on, 30 frames off).
module gameover_overlay_ctrl
    import boxhead_sprite_pkg::*;
#(
    parameter int SPRITE_W  = GO_SPRITE_W,
    parameter int SPRITE_H  = GO_SPRITE_H,
    parameter int X0        = GO_X0,
    parameter int Y_TARGET  = GO_Y_TARGET,
    parameter int DROP_STEP = GO_DROP_STEP
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 game_over,
    input  logic                 restart,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic [GO_ROM_AW-1:0] rom_addr,
    input  logic [GO_IDX_W-1:0]  rom_data,
    output logic                 overlay_valid,
    output logic [GO_IDX_W-1:0]  overlay_idx,
    output logic                 active,
    output logic                 settled
);

    go_state_t  state_d, state_q;
    logic [9:0] y_pos_d, y_pos_q;
    logic [9:0] y_step;
    logic       go_prev_d, go_prev_q;
    logic       go_edge;
    logic       in_box_d1;
    logic       in_box_d2_d, in_box_d2_q;
    logic       vis;

    // ---------------- state / drop position ----------------
    always_comb begin
        go_prev_d = game_over;
        go_edge   = game_over & ~go_prev_q;
        y_step    = y_pos_q + 10'(DROP_STEP);
        state_d   = state_q;
        y_pos_d   = y_pos_q;
        if (restart) begin
            state_d = GO_IDLE;
            y_pos_d = '0;
        end else begin
            case (state_q)
                GO_IDLE: begin
                    // A tick in the entry cycle is deliberately not applied.
                    if (go_edge) begin
                        state_d = GO_DROP;
                        y_pos_d = '0;
                    end
                end
                GO_DROP: begin
                    if (frame_tick) begin
                        if (y_step >= 10'(Y_TARGET)) begin
                            y_pos_d = 10'(Y_TARGET);
                            state_d = GO_SHOW;
                        end else begin
                            y_pos_d = y_step;
                        end
                    end
                end
                GO_SHOW: y_pos_d = 10'(Y_TARGET);
                default: begin
                    state_d = GO_IDLE;
                    y_pos_d = '0;
                end
            endcase
        end
    end

    // go_prev follows game_over even in reset, so a level already high when
    // reset releases is not seen as a start.
    always_ff @(posedge Clk) begin
        go_prev_q <= go_prev_d;
        if (Reset) begin
            state_q <= GO_IDLE;
            y_pos_q <= '0;
        end else begin
            state_q <= state_d;
            y_pos_q <= y_pos_d;
        end
    end

    assign active  = (state_q != GO_IDLE);
    assign settled = (state_q == GO_SHOW);

`ifdef GAMEOVER_BLINK_EN
    logic [5:0] blink_cnt_d, blink_cnt_q;
    logic       vis_d, vis_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        if (restart || (state_q != GO_SHOW && state_d == GO_SHOW)) begin
            blink_cnt_d = '0;
            vis_d       = 1'b1;
        end else if (state_q == GO_SHOW && frame_tick) begin
            if (blink_cnt_q == 6'd29) begin
                blink_cnt_d = '0;
                vis_d       = ~vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt_q <= '0;
            vis_q       <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
        end
    end

    assign vis = vis_q;
`else
    assign vis = 1'b1;
`endif

    // ---------------- pixel pipeline ----------------
    // Stage 1: hit test and address register.
    sprite_addr_gen #(.AW(GO_ROM_AW)) u_addr_gen (
        .clk      (Clk),
        .reset    (Reset),
        .en       (active),
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .x0       (10'(X0)),
        .y0       (y_pos_q),
        .w        (10'(SPRITE_W)),
        .h        (10'(SPRITE_H)),
        .rom_addr (rom_addr),
        .in_box   (in_box_d1)
    );

    // Stage 2: hit flag re-aligned with the ROM read data.
    assign in_box_d2_d = in_box_d1;

    always_ff @(posedge Clk) begin
        if (Reset) in_box_d2_q <= 1'b0;
        else       in_box_d2_q <= in_box_d2_d;
    end

    assign overlay_valid = in_box_d2_q & (rom_data != TRANSPARENT_IDX) & vis;
    assign overlay_idx   = overlay_valid ? rom_data : '0;

endmodule

// File: tb/tb_gameover_overlay_ctrl.sv
module tb_gameover_overlay_ctrl;

`ifdef GAMEOVER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, frame_tick, game_over, restart;
    logic [9:0]  DrawX, DrawY;
    logic [14:0] rom_addr;
    logic [4:0]  rom_data;
    logic        overlay_valid, active, settled;
    logic [4:0]  overlay_idx;

    gameover_overlay_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_over(game_over),
        .restart(restart), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
        .rom_data(rom_data), .overlay_valid(overlay_valid), .overlay_idx(overlay_idx),
        .active(active), .settled(settled)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    // Sprite ROM stand-in: word 0 is 7, a sprinkling of transparent words.
    function automatic int rom_word(int a);
        if (a % 13 == 5) return 0;
        return (a * 7 + 7) % 32;
    endfunction

    logic [4:0] rom [0:5274];
    always @(posedge Clk) rom_data <= (rom_addr <= 15'd5274) ? rom[rom_addr] : 5'd0;

    // Reference model: banner state, drop position, blink, pipeline of expectations.
    int m_st = 0;   // 0 idle, 1 dropping, 2 shown
    int m_y = 0, m_cnt = 0;
    bit m_vis = 1'b1, m_goprev = 1'b0;
    bit e_in1 = 1'b0, e_in2 = 1'b0;
    int e_addr1 = 0, e_addr2 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        bit inb, ge, exp_v;
        int addr, dx, dy;
        dx  = int'(DrawX);
        dy  = int'(DrawY);
        inb = (m_st != 0) && dx >= 214 && dx < 214 + 211 && dy >= m_y && dy < m_y + 25;
        addr = inb ? (dy - m_y) * 211 + (dx - 214) : 0;
        ge  = game_over && !m_goprev;
        @(posedge Clk);
        #1;
        m_goprev = game_over;
        if (Reset) begin
            m_st = 0; m_y = 0; m_cnt = 0; m_vis = 1'b1;
            e_in1 = 1'b0; e_in2 = 1'b0; e_addr1 = 0; e_addr2 = 0;
        end else begin
            e_in2 = e_in1; e_addr2 = e_addr1;
            e_in1 = inb;   e_addr1 = addr;
            if (restart) begin
                m_st = 0; m_y = 0; m_cnt = 0; m_vis = 1'b1;
            end else if (m_st == 0) begin
                if (ge) begin m_st = 1; m_y = 0; end
            end else if (m_st == 1) begin
                if (frame_tick) begin
                    m_y = (m_y + 4 > 227) ? 227 : m_y + 4;
                    if (m_y == 227) begin m_st = 2; m_cnt = 0; m_vis = 1'b1; end
                end
            end else if (BLINK && frame_tick) begin
                m_cnt++;
                if (m_cnt == 30) begin m_cnt = 0; m_vis = !m_vis; end
            end
        end
        exp_v = e_in2 && rom_word(e_addr2) != 0 && (m_vis || !BLINK);
        chk("model_rom_addr", int'(rom_addr), e_addr1);
        chk("model_valid", int'(overlay_valid), int'(exp_v));
        chk("model_idx", int'(overlay_idx), exp_v ? rom_word(e_addr2) : 0);
        chk("model_active", int'(active), int'(m_st != 0));
        chk("model_settled", int'(settled), int'(m_st == 2));
    endtask

    task automatic tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
    endtask

    task automatic probe_y(input string nm, input int y);
        DrawX = 10'd215; DrawY = 10'(y); step();
        chk(nm, int'(rom_addr), 1);
        DrawX = 10'd0; DrawY = 10'd0;
    endtask

    typedef struct {
        string nm;
        int    dx, dy, addr, v, idx;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{"origin",      214, 227,    0, 1,  7};
        tbl[1] = '{"far_corner",  424, 251, 5274, 1, 29};
        tbl[2] = '{"left_out",    213, 227,    0, 0,  0};
        tbl[3] = '{"right_out",   425, 227,    0, 0,  0};
        tbl[4] = '{"top_out",     214, 226,    0, 0,  0};
        tbl[5] = '{"bottom_out",  214, 252,    0, 0,  0};
        tbl[6] = '{"transp_word", 219, 227,    5, 0,  0};
        tbl[7] = '{"mid",         300, 240, 2829, 1,  2};
        tbl[8] = '{"blanking",    700, 500,    0, 0,  0};
        for (int a = 0; a <= 5274; a++) rom[a] = 5'(rom_word(a));

        Reset = 1'b1; game_over = 1'b1; restart = 1'b0; frame_tick = 1'b0;
        DrawX = 10'd214; DrawY = 10'd0;
        repeat (3) step();
        chk("reset_active", int'(active), 0);
        chk("reset_settled", int'(settled), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_valid", int'(overlay_valid), 0);
        chk("reset_idx", int'(overlay_idx), 0);

        Reset = 1'b0;
        repeat (4) step();
        chk("held_go_no_start", int'(active), 0);

        game_over = 1'b0; step();
        game_over = 1'b1; step();
        chk("drop_entry_active", int'(active), 1);
        chk("drop_entry_settled", int'(settled), 0);
        probe_y("drop_y0", 0);

        for (int k = 1; k <= 57; k++) begin
            int ey;
            ey = (4 * k > 227) ? 227 : 4 * k;
            tick();
            chk("settled_after_tick", int'(settled), int'(k == 57));
            probe_y("drop_y_probe", ey);
            DrawX = 10'd215; DrawY = 10'(ey - 1); step();
            chk("drop_y_above", int'(rom_addr), 0);
        end
        repeat (3) begin
            tick();
            probe_y("show_y_hold", 227);
        end

        foreach (tbl[i]) begin
            DrawX = 10'(tbl[i].dx); DrawY = 10'(tbl[i].dy); step();
            chk({tbl[i].nm, "_addr"}, int'(rom_addr), tbl[i].addr);
            DrawX = 10'd0; DrawY = 10'd0; step();
            chk({tbl[i].nm, "_valid"}, int'(overlay_valid), tbl[i].v);
            chk({tbl[i].nm, "_idx"}, int'(overlay_idx), tbl[i].idx);
        end

        // Banner visibility per frame since entering SHOW (3 ticks so far).
        DrawX = 10'd214; DrawY = 10'd227;
        for (int f = 4; f <= 65; f++) begin
            tick(); step(); step();
            chk("blink_visible", int'(overlay_valid), BLINK ? int'((f / 30) % 2 == 0) : 1);
        end

        // Restart beats a same-cycle start edge mid-drop.
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_from_show", int'(active), 0);
        game_over = 1'b0; step(); game_over = 1'b1; step();
        repeat (5) tick();
        game_over = 1'b0; step();
        game_over = 1'b1; restart = 1'b1; step(); restart = 1'b0;
        chk("restart_wins_active", int'(active), 0);
        chk("restart_wins_settled", int'(settled), 0);
        step();
        chk("restart_stays_idle", int'(active), 0);
        game_over = 1'b0; step(); game_over = 1'b1; step();
        probe_y("restart_y_zero", 0);

        // Reset mid-drop.
        repeat (6) tick();
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("reset_mid_drop_active", int'(active), 0);
        game_over = 1'b0; step(); game_over = 1'b1; step();
        probe_y("reset_y_zero", 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            Reset      = ($urandom % 500) == 0;
            restart    = ($urandom % 300) == 0;
            frame_tick = ($urandom % 6) == 0;
            if (($urandom % 50) == 0) game_over = ~game_over;
            DrawX = 10'($urandom_range(200, 440));
            DrawY = 10'($urandom_range(0, 280));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
